// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared widths, PC constants and state codes for the fetch front end.
// The execute-stage branch checker imports the same definitions.
package fetch_pc_ctrl_pkg;

    localparam int FULLW       = 32;
    localparam int BRANCHIMM_W = 24;
    localparam int FETCH_ST_W  = 2;
    localparam int FLUSH_CNT_W = 3;

    localparam logic [FULLW-1:0] PC_STEP  = 32'd4;
    localparam logic [FULLW-1:0] PC_AHEAD = 32'd8;

    typedef enum logic [FETCH_ST_W-1:0] {
        FST_BOOT  = 2'd0,
        FST_RUN   = 2'd1,
        FST_FLUSH = 2'd2,
        FST_HALT  = 2'd3
    } fetch_state_e;

    // Sequential fetch step; wraps mod 2^FULLW.
    function automatic logic [FULLW-1:0] pc_next(input logic [FULLW-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_pc_ctrl_branch_target.sv
// Branch target: branch_pc + PC_AHEAD + (sext(imm) << 2), word aligned.
// Kept separate so the execute-stage branch checker computes the identical target.
module branch_target
    import fetch_pc_ctrl_pkg::*;
(
    input  logic [FULLW-1:0]       i_branch_pc,
    input  logic [BRANCHIMM_W-1:0] i_imm,
    output logic [FULLW-1:0]       o_target
);

    logic [FULLW-1:0] w_offset;
    logic [FULLW-1:0] w_sum;

    assign w_offset = {{(FULLW-BRANCHIMM_W-2){i_imm[BRANCHIMM_W-1]}}, i_imm, 2'b00};
    assign w_sum    = i_branch_pc + PC_AHEAD + w_offset;
    assign o_target = {w_sum[FULLW-1:2], 2'b00};

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: steps the PC, redirects on taken branches, squashes
// FLUSH_DEPTH wrong-path fetches, and parks on a sticky halt.
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR  = 32'h0000_0000,
    parameter int          FLUSH_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall_in,
    input  logic                   branch_taken_in,
    input  logic [FULLW-1:0]       branch_pc_in,
    input  logic [BRANCHIMM_W-1:0] branch_imm_in,
    input  logic                   halt_in,
    output logic [FULLW-1:0]       instr_addr_out,
    output logic                   make_invalid_out,
    output logic                   halted_out
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LAST = FLUSH_CNT_W'(FLUSH_DEPTH - 1);

    fetch_state_e            r_state;
    logic [FULLW-1:0]        r_pc;
    logic [FLUSH_CNT_W-1:0]  r_cnt;
    logic                    r_inv;
    logic                    r_halted;
    logic [FULLW-1:0]        w_target;

    branch_target u_branch_target (
        .i_branch_pc (branch_pc_in),
        .i_imm       (branch_imm_in),
        .o_target    (w_target)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= FST_BOOT;
            r_pc     <= RESET_ADDR;
            r_cnt    <= '0;
            r_inv    <= 1'b1;
            r_halted <= 1'b0;
        end else if (halt_in) begin
            r_state  <= FST_HALT;
            r_inv    <= 1'b1;
            r_halted <= 1'b1;
        end else begin
            case (r_state)
                // First instruction RAM read is undefined; burn one cycle.
                FST_BOOT: begin
                    r_state <= FST_RUN;
                    r_inv   <= 1'b0;
                end
                FST_RUN: begin
                    if (branch_taken_in) begin
                        r_pc    <= w_target;
                        r_cnt   <= FLUSH_LAST;
                        r_state <= FST_FLUSH;
                        r_inv   <= 1'b1;
                    end else if (!stall_in) begin
                        r_pc  <= pc_next(r_pc);
                        r_inv <= 1'b0;
                    end
                end
                // Branches seen here come from squashed instructions and are ignored.
                FST_FLUSH: begin
                    r_inv <= 1'b1;
                    if (!stall_in) begin
                        r_pc <= pc_next(r_pc);
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else begin
                            r_state <= FST_RUN;
                            r_inv   <= 1'b0;
                        end
                    end
                end
                FST_HALT: begin
                    r_inv    <= 1'b1;
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= FST_BOOT;
                    r_inv   <= 1'b1;
                end
            endcase
        end
    end

    assign instr_addr_out   = r_pc;
    assign make_invalid_out = r_inv;
    assign halted_out       = r_halted;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl; a second instance covers PC wrap from a high RESET_ADDR.
module tb_fetch_pc_ctrl;
    import fetch_pc_ctrl_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   stall_in = 1'b0;
    logic                   branch_taken_in = 1'b0;
    logic [FULLW-1:0]       branch_pc_in = '0;
    logic [BRANCHIMM_W-1:0] branch_imm_in = '0;
    logic                   halt_in = 1'b0;
    logic [FULLW-1:0]       instr_addr_out;
    logic                   make_invalid_out;
    logic                   halted_out;

    logic [FULLW-1:0]       w_addr;
    logic                   w_inv;
    logic                   w_halted;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_pc_ctrl #(.RESET_ADDR(32'h0000_0000), .FLUSH_DEPTH(2)) u_dut (
        .clk              (clk),
        .reset            (reset),
        .stall_in         (stall_in),
        .branch_taken_in  (branch_taken_in),
        .branch_pc_in     (branch_pc_in),
        .branch_imm_in    (branch_imm_in),
        .halt_in          (halt_in),
        .instr_addr_out   (instr_addr_out),
        .make_invalid_out (make_invalid_out),
        .halted_out       (halted_out)
    );

    fetch_pc_ctrl #(.RESET_ADDR(32'hFFFF_FFF8), .FLUSH_DEPTH(2)) u_dut_wrap (
        .clk              (clk),
        .reset            (reset),
        .stall_in         (1'b0),
        .branch_taken_in  (1'b0),
        .branch_pc_in     (32'h0),
        .branch_imm_in    (24'h0),
        .halt_in          (1'b0),
        .instr_addr_out   (w_addr),
        .make_invalid_out (w_inv),
        .halted_out       (w_halted)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] a, input logic inv, input logic hlt);
        chk({tag, ".addr"}, instr_addr_out, a);
        chk({tag, ".inv"}, {31'b0, make_invalid_out}, {31'b0, inv});
        chk({tag, ".halt"}, {31'b0, halted_out}, {31'b0, hlt});
    endtask

    initial begin
        // T1 / T5: reset state, then release mid-cycle
        step;
        chk_out("rst", 32'h0, 1'b1, 1'b0);
        chk("wrap.rst", w_addr, 32'hFFFF_FFF8);
        chk("wrap.rst.inv", {31'b0, w_inv}, 32'd1);
        reset = 1'b0;
        step;
        chk_out("t1.boot", 32'h0, 1'b0, 1'b0);
        chk("wrap.e1", w_addr, 32'hFFFF_FFF8);
        step;
        chk_out("t1.e2", 32'h4, 1'b0, 1'b0);
        chk("wrap.e2", w_addr, 32'hFFFF_FFFC);
        step;
        chk_out("t1.e3", 32'h8, 1'b0, 1'b0);
        chk("wrap.e3", w_addr, 32'h0000_0000);
        step;
        chk_out("t1.e4", 32'hC, 1'b0, 1'b0);
        chk("wrap.e4", w_addr, 32'h0000_0004);
        chk("wrap.halt", {31'b0, w_halted}, 32'd0);

        // Run up to PC=0x40
        for (int i = 0; i < 13; i++) step;
        chk_out("t2.pre", 32'h40, 1'b0, 1'b0);

        // T2: positive offset redirect, 2-cycle squash
        branch_taken_in = 1'b1;
        branch_pc_in    = 32'h20;
        branch_imm_in   = 24'h000003;
        step;
        branch_taken_in = 1'b0;
        chk_out("t2.tgt", 32'h34, 1'b1, 1'b0);
        step;
        chk_out("t2.f2", 32'h38, 1'b1, 1'b0);
        step;
        chk_out("t2.valid", 32'h3C, 1'b0, 1'b0);
        step;
        chk_out("t2.next", 32'h40, 1'b0, 1'b0);

        // Stall in RUN holds PC and validity
        stall_in = 1'b1;
        step;
        chk_out("run.stall", 32'h40, 1'b0, 1'b0);

        // T3: negative offset, redirect overrides stall
        branch_taken_in = 1'b1;
        branch_pc_in    = 32'h100;
        branch_imm_in   = 24'hFFFFFE;
        step;
        chk_out("t3.tgt", 32'h100, 1'b1, 1'b0);

        // T4: stall 3 cycles in FLUSH with stray branches
        branch_pc_in  = 32'h800;
        branch_imm_in = 24'h000000;
        for (int i = 0; i < 3; i++) begin
            branch_taken_in = (i == 1);
            step;
            chk_out("t4.stall", 32'h100, 1'b1, 1'b0);
        end
        stall_in        = 1'b0;
        branch_taken_in = 1'b1;
        step;
        branch_taken_in = 1'b0;
        chk_out("t4.f2", 32'h104, 1'b1, 1'b0);
        step;
        chk_out("t4.valid", 32'h108, 1'b0, 1'b0);
        step;
        chk_out("t4.next", 32'h10C, 1'b0, 1'b0);

        // T6: halt during FLUSH
        branch_taken_in = 1'b1;
        branch_pc_in    = 32'h200;
        branch_imm_in   = 24'h000000;
        step;
        chk_out("t6.tgt", 32'h208, 1'b1, 1'b0);
        halt_in = 1'b1;
        step;
        halt_in = 1'b0;
        chk_out("t6.halt", 32'h208, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            stall_in = i[0];
            step;
            chk_out("t6.hold", 32'h208, 1'b1, 1'b1);
        end
        branch_taken_in = 1'b0;
        stall_in        = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_out("t6.async", 32'h0, 1'b1, 1'b0);
        step;
        reset = 1'b0;
        chk_out("t6.rsthold", 32'h0, 1'b1, 1'b0);
        step;
        chk_out("t6.boot", 32'h0, 1'b0, 1'b0);
        step;
        chk_out("t6.run", 32'h4, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
